mer_power_accum: RTL and testbench

MER_POWER_ACCUM -- requirements
Module: mer_power_accum

---
 rtl/mer_power_accum.sv | 118 +++++++++++
 tb/tb_mer_power_accum.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mer_power_accum.sv
// Windowed reference/error power averager feeding the MER lookup.
// The per-symbol power stage is followed by a FILL/DUMP window accumulator.
module mer_power_accum #(
    parameter int LOG2_WIN  = 10,
    parameter int PWR_SHIFT = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic signed [17:0] ref_i,
    input  logic signed [17:0] ref_q,
    input  logic signed [17:0] err_i,
    input  logic signed [17:0] err_q,
    output logic signed [17:0] mapper_power,
    output logic signed [17:0] error_power,
    output logic               power_valid,
    output logic               clamp_flag
);

    localparam int PR_W  = 37 - PWR_SHIFT;
    localparam int ACC_W = PR_W + LOG2_WIN;
    localparam int EXT_W = (PR_W > 17) ? PR_W : 17;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] DUMP = 1'b1;

    // Exact 36-bit squares and 37-bit sum; the shift is the only truncation.
    function automatic logic [PR_W-1:0] sym_pwr(
        input logic signed [17:0] a,
        input logic signed [17:0] b
    );
        logic signed [35:0] pa;
        logic signed [35:0] pb;
        logic [36:0]        s;
        pa = 36'(a) * 36'(a);
        pb = 36'(b) * 36'(b);
        s  = {1'b0, pa} + {1'b0, pb};
        return PR_W'(s >> PWR_SHIFT);
    endfunction

    logic [PR_W-1:0]     pr_q;
    logic [PR_W-1:0]     pe_q;
    logic                s1_valid;
    logic [0:0]          state;
    logic [ACC_W-1:0]    acc_m;
    logic [ACC_W-1:0]    acc_e;
    logic [LOG2_WIN-1:0] cnt;
    logic [EXT_W-1:0]    avg_m;
    logic [EXT_W-1:0]    avg_e;
    logic                clamp_m;
    logic                clamp_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            pr_q     <= '0;
            pe_q     <= '0;
        end else begin
            s1_valid <= clk_en;
            if (clk_en) begin
                pr_q <= sym_pwr(ref_i, ref_q);
                pe_q <= sym_pwr(err_i, err_q);
            end
        end
    end

    assign avg_m   = EXT_W'(acc_m >> LOG2_WIN);
    assign avg_e   = EXT_W'(acc_e >> LOG2_WIN);
    assign clamp_m = avg_m > EXT_W'(131071);
    assign clamp_e = avg_e > EXT_W'(131071);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            acc_m        <= '0;
            acc_e        <= '0;
            cnt          <= '0;
            mapper_power <= '0;
            error_power  <= '0;
            power_valid  <= 1'b0;
            clamp_flag   <= 1'b0;
        end else begin
            power_valid <= 1'b0;
            unique case (state)
                FILL: begin
                    if (s1_valid) begin
                        acc_m <= acc_m + ACC_W'(pr_q);
                        acc_e <= acc_e + ACC_W'(pe_q);
                        cnt   <= cnt + 1'b1;
                        if (&cnt)
                            state <= DUMP;
                    end
                end
                DUMP: begin
                    mapper_power <= clamp_m ? 18'sd131071
                                            : $signed({1'b0, avg_m[16:0]});
                    error_power  <= clamp_e ? 18'sd131071
                                            : $signed({1'b0, avg_e[16:0]});
                    clamp_flag   <= clamp_m | clamp_e;
                    power_valid  <= 1'b1;
                    state        <= FILL;
                    // A symbol landing on the dump cycle opens the next window.
                    if (s1_valid) begin
                        acc_m <= ACC_W'(pr_q);
                        acc_e <= ACC_W'(pe_q);
                        cnt   <= LOG2_WIN'(1);
                    end else begin
                        acc_m <= '0;
                        acc_e <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_mer_power_accum.sv
// Bench for mer_power_accum: two instances (PWR_SHIFT 20 and 18) share
// stimulus and are checked every cycle against a window-sum reference model.
module tb_mer_power_accum;

    logic               clk;
    logic               reset;
    logic               clk_en;
    logic signed [17:0] ref_i, ref_q, err_i, err_q;
    logic signed [17:0] mp_a, ep_a, mp_b, ep_b;
    logic               pv_a, cf_a, pv_b, cf_b;

    mer_power_accum #(.LOG2_WIN(2), .PWR_SHIFT(20)) dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .ref_i(ref_i), .ref_q(ref_q), .err_i(err_i), .err_q(err_q),
        .mapper_power(mp_a), .error_power(ep_a),
        .power_valid(pv_a), .clamp_flag(cf_a)
    );

    mer_power_accum #(.LOG2_WIN(2), .PWR_SHIFT(18)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .ref_i(ref_i), .ref_q(ref_q), .err_i(err_i), .err_q(err_q),
        .mapper_power(mp_b), .error_power(ep_b),
        .power_valid(pv_b), .clamp_flag(cf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        longint t;
        longint m0, m1, e0, e1;
        bit     c0, c1;
    } pulse_t;

    pulse_t q[$];
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    int     pulses = 0;
    int     nsym = 0;
    longint sm0 = 0, sm1 = 0, se0 = 0, se1 = 0;
    longint xm0 = 0, xm1 = 0, xe0 = 0, xe1 = 0;
    bit     xc0 = 0, xc1 = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: got %0d expected %0d",
                   tag, cyc, obs, exp);
        end
    endtask

    function automatic longint pwr(input longint a, input longint b,
                                   input int sh);
        return (a * a + b * b) >>> sh;
    endfunction

    function automatic longint avg_clamp(input longint s);
        longint v;
        v = s / 4;
        return (v > 131071) ? 131071 : v;
    endfunction

    task automatic step(input bit rst, input bit en,
                        input longint ri, input longint rq,
                        input longint ei, input longint eq);
        pulse_t p;
        bit     ev;
        reset  = rst;
        clk_en = en;
        ref_i  = 18'(ri);
        ref_q  = 18'(rq);
        err_i  = 18'(ei);
        err_q  = 18'(eq);
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            nsym = 0;
            sm0 = 0; sm1 = 0; se0 = 0; se1 = 0;
            xm0 = 0; xm1 = 0; xe0 = 0; xe1 = 0;
            xc0 = 0; xc1 = 0;
        end else if (en) begin
            sm0 += pwr(ri, rq, 20);
            sm1 += pwr(ri, rq, 18);
            se0 += pwr(ei, eq, 20);
            se1 += pwr(ei, eq, 18);
            nsym++;
            if (nsym == 4) begin
                p.t  = cyc + 2;
                p.m0 = avg_clamp(sm0);
                p.m1 = avg_clamp(sm1);
                p.e0 = avg_clamp(se0);
                p.e1 = avg_clamp(se1);
                p.c0 = (sm0 / 4 > 131071) || (se0 / 4 > 131071);
                p.c1 = (sm1 / 4 > 131071) || (se1 / 4 > 131071);
                q.push_back(p);
                nsym = 0;
                sm0 = 0; sm1 = 0; se0 = 0; se1 = 0;
            end
        end
        #1;
        ev = (q.size() > 0) && (q[0].t == cyc);
        if (ev) begin
            p = q.pop_front();
            xm0 = p.m0; xm1 = p.m1; xe0 = p.e0; xe1 = p.e1;
            xc0 = p.c0; xc1 = p.c1;
        end
        if (pv_a) pulses++;
        chk("a_valid", longint'(pv_a), longint'(ev));
        chk("a_mapper", longint'(mp_a), xm0);
        chk("a_error", longint'(ep_a), xe0);
        chk("a_clamp", longint'(cf_a), longint'(xc0));
        chk("b_valid", longint'(pv_b), longint'(ev));
        chk("b_mapper", longint'(mp_b), xm1);
        chk("b_error", longint'(ep_b), xe1);
        chk("b_clamp", longint'(cf_b), longint'(xc1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int p0;
        reset = 1'b1; clk_en = 1'b0;
        ref_i = '0; ref_q = '0; err_i = '0; err_q = '0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32768, 32768, 2048, 2048);
        chk("reset_valid", longint'(pv_a), 0);
        chk("reset_mapper", longint'(mp_a), 0);
        idle(3);

        // Baseline window
        p0 = pulses;
        for (int i = 0; i < 4; i++) step(0, 1, 32768, 32768, 2048, 2048);
        idle(2);
        chk("base_lat_pulse", longint'(pv_a), 1);
        chk("base_mapper", longint'(mp_a), 2048);
        chk("base_error", longint'(ep_a), 8);
        chk("base_clamp", longint'(cf_a), 0);
        idle(3);
        chk("base_hold", longint'(mp_a), 2048);

        // Gapped strobe, every third cycle
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32768, 32768, 4096, 0);
            idle(2);
        end
        idle(3);
        chk("gap_pulses", longint'(pulses - p0), 2);
        chk("gap_error", longint'(ep_a), 16);
        chk("gap_mapper", longint'(mp_a), 2048);

        // Continuous stream across window boundaries
        p0 = pulses;
        for (int i = 0; i < 12; i++)
            step(0, 1, 32768, 32768, (i % 2) ? 2048 : 0, 0);
        idle(4);
        chk("cont_pulses", longint'(pulses - p0), 3);
        chk("cont_error", longint'(ep_a), 2);

        // Clamp then recovery
        for (int i = 0; i < 4; i++) step(0, 1, -131072, -131072, 0, 0);
        idle(3);
        chk("clamp_mapper", longint'(mp_b), 131071);
        chk("clamp_flag", longint'(cf_b), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        idle(3);
        chk("unclamp_mapper", longint'(mp_b), 0);
        chk("unclamp_flag", longint'(cf_b), 0);

        // Reset mid-window
        for (int i = 0; i < 2; i++) step(0, 1, 32768, 32768, 2048, 2048);
        step(1, 0, 0, 0, 0, 0);
        p0 = pulses;
        for (int i = 0; i < 4; i++) step(0, 1, 32768, 32768, 2048, 2048);
        idle(5);
        chk("rst_pulses", longint'(pulses - p0), 1);
        chk("rst_mapper", longint'(mp_a), 2048);
        chk("rst_error", longint'(ep_a), 8);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) != 0),
                 longint'($signed(18'($urandom))),
                 longint'($signed(18'($urandom))),
                 longint'($signed(18'($urandom))),
                 longint'($signed(18'($urandom))));
        end
        idle(6);
        chk("pending_drained", longint'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
